// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- reusable inter-stage pipeline register for the MISC-V
// datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one control bundle and
// one data bundle between adjacent stages. It has a valid/ready handshake, a
// synchronous flush, and a control bundle that is forced to zero on bubbles.
//
// Build option: define PIPE_STAGE_SKID_EN to get the two-entry skid buffer.
// In that build in_ready has no combinational path from out_ready. Without
// the macro the block is a depth-1 register, and in_ready depends
// combinationally on out_ready.
//
// Parameters:
//   CTRL_W     width of the control bundle (zeroed on bubbles)
//   DATA_W     width of the data bundle (passed through unmodified)
// Ports:
//   CLK        rising-edge clock
//   Reset      asynchronous active-low reset
//   flush      synchronous discard of all held beats
//   in_valid   upstream offers a beat
//   in_ready   block accepts the beat this cycle
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   out_valid  beat presented downstream
//   out_ready  downstream consumes the beat this cycle
//   out_ctrl   control bundle, all-zero while out_valid=0
//   out_data   data bundle, holds its last value while out_valid=0
//   occupancy  number of held beats

module pipe_stage_reg #(
   parameter int unsigned CTRL_W = 4,
   parameter int unsigned DATA_W = 48
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   localparam int unsigned OCC_W = 2;

   // Main register M: this register drives the outputs.
   logic              m_valid_q, m_valid_d;
   logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;

   logic accept_c;
   logic consume_c;

   assign consume_c = m_valid_q & out_ready;
   assign accept_c  = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
   // Skid register S: it only fills while M is full and stalled.
   logic              s_valid_q, s_valid_d;
   logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;

   // Ready depends only on state and reset, so there is no path from out_ready.
   assign in_ready = Reset & ~s_valid_q;

   // Next-state logic. Flush has top priority. An empty or draining M
   // refills from S first, which preserves beat order.
   always_comb begin
      m_valid_d = m_valid_q;
      m_ctrl_d  = m_ctrl_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_ctrl_d  = s_ctrl_q;
      s_data_d  = s_data_q;

      if (flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!m_valid_q || consume_c) begin
         if (s_valid_q) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = s_ctrl_q;
            m_data_d  = s_data_q;
            s_valid_d = accept_c;
            if (accept_c) begin
               s_ctrl_d = in_ctrl;
               s_data_d = in_data;
            end
         end else if (accept_c) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = in_ctrl;
            m_data_d  = in_data;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (accept_c) begin
         s_valid_d = 1'b1;
         s_ctrl_d  = in_ctrl;
         s_data_d  = in_data;
      end
   end

   // State registers.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         m_valid_q <= 1'b0;
         m_ctrl_q  <= '0;
         m_data_q  <= '0;
         s_valid_q <= 1'b0;
         s_ctrl_q  <= '0;
         s_data_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_ctrl_q  <= m_ctrl_d;
         m_data_q  <= m_data_d;
         s_valid_q <= s_valid_d;
         s_ctrl_q  <= s_ctrl_d;
         s_data_q  <= s_data_d;
      end
   end

   assign occupancy = OCC_W'(m_valid_q) + OCC_W'(s_valid_q);
`else
   // Depth-1 build: M can take a new beat in the same cycle it is consumed.
   assign in_ready = Reset & (~m_valid_q | out_ready);

   // Next-state logic. Flush drops both the held beat and any beat
   // accepted in the same cycle.
   always_comb begin
      m_valid_d = m_valid_q;
      m_ctrl_d  = m_ctrl_q;
      m_data_d  = m_data_q;

      if (flush) begin
         m_valid_d = 1'b0;
      end else if (!m_valid_q || consume_c) begin
         if (accept_c) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = in_ctrl;
            m_data_d  = in_data;
         end else begin
            m_valid_d = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         m_valid_q <= 1'b0;
         m_ctrl_q  <= '0;
         m_data_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_ctrl_q  <= m_ctrl_d;
         m_data_q  <= m_data_d;
      end
   end

   assign occupancy = {1'b0, m_valid_q};
`endif

   // Bubbles present an all-zero control bundle, so no write enable leaks downstream.
   assign out_valid = m_valid_q;
   assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
   assign out_data  = m_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam int unsigned CW = 4;
   localparam int unsigned DW = 16;
`ifdef PIPE_STAGE_SKID_EN
   localparam int MAX_OCC = 2;
`else
   localparam int MAX_OCC = 1;
`endif

   logic          CLK = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   int errors = 0;
   int checks = 0;

   logic [CW+DW-1:0] sb[$];
   logic [CW+DW-1:0] exp_beat;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
      .CLK       (CLK),
      .Reset     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 CLK = ~CLK;

   // Scoreboard monitor. It samples mid-cycle: it pops and compares on
   // Consume, and pushes on Accept.
   always @(negedge CLK) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         checks++;
         if (occupancy !== 2'(sb.size())) begin
            errors++;
            $display("FAIL sb_occupancy: got %0d, required %0d", occupancy, sb.size());
         end
         checks++;
         if (out_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL sb_out_valid: got %b, required %b", out_valid, sb.size() != 0);
         end
         if (!out_valid) begin
            checks++;
            if (out_ctrl !== '0) begin
               errors++;
               $display("FAIL sb_bubble_ctrl: got %h, required 0", out_ctrl);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_beat: got ctrl=%h data=%h, required none", out_ctrl, out_data);
            end else begin
               exp_beat = sb.pop_front();
               if ({out_ctrl, out_data} !== exp_beat) begin
                  errors++;
                  $display("FAIL sb_beat: got %h/%h, required %h/%h",
                           out_ctrl, out_data, exp_beat[CW+DW-1:DW], exp_beat[DW-1:0]);
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
      end
   end

   task automatic drive(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
      @(posedge CLK);
      #1;
      in_valid  = iv;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_ctrl = 4'hF; in_data = 16'h1234;
      out_ready = 1'b1; flush = 1'b1;
      repeat (2) @(negedge CLK);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      checks++; if (out_ctrl !== 4'h0) begin errors++; $display("FAIL reset_out_ctrl: got %h, required 0", out_ctrl); end
      checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d, required 0", occupancy); end
      @(posedge CLK); #1;
      rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
      @(negedge CLK);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b, required 1", in_ready); end
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 4'h9, DW'(i), 1'b1, 1'b0);
         #2;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b, required 1", in_ready); end
         if (i > 1) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap: got out_valid=%b, required 1", out_valid); end
            checks++; if (out_data !== DW'(i - 1)) begin errors++; $display("FAIL stream_latency: got %h, required %h", out_data, DW'(i - 1)); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occupancy: got %0d, required 1", occupancy); end
         end
      end
      drive(1'b0, 4'h9, 16'h0, 1'b1, 1'b0);
      #2;
      checks++; if (out_data !== 16'h0008) begin errors++; $display("FAIL stream_last: got %h, required 0008", out_data); end
      drive(1'b0, 4'h9, 16'h0, 1'b1, 1'b0);
      #2;
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drained: got %0d, required 0", occupancy); end
   endtask

   task automatic test_bubble();
      drive(1'b1, 4'h9, 16'h55AA, 1'b1, 1'b0);
      drive(1'b0, 4'hF, 16'hDEAD, 1'b1, 1'b0);
      #2;
      checks++; if (out_ctrl !== 4'h9) begin errors++; $display("FAIL bubble_valid_ctrl: got %h, required 9", out_ctrl); end
      drive(1'b0, 4'hF, 16'hDEAD, 1'b1, 1'b0);
      #2;
      checks++; if (out_ctrl !== 4'h0) begin errors++; $display("FAIL bubble_ctrl: got %h, required 0", out_ctrl); end
      checks++; if (out_data !== 16'h55AA) begin errors++; $display("FAIL bubble_data_hold: got %h, required 55AA", out_data); end
   endtask

`ifdef PIPE_STAGE_SKID_EN
   task automatic test_stall();
      drive(1'b1, 4'h6, 16'hA000, 1'b0, 1'b0);
      drive(1'b1, 4'h6, 16'hA001, 1'b0, 1'b0);
      #2;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_absorb_ready: got %b, required 1", in_ready); end
      drive(1'b1, 4'h6, 16'hA002, 1'b0, 1'b0);
      #2;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL stall_occupancy: got %0d, required 2", occupancy); end
      drive(1'b1, 4'h6, 16'hA002, 1'b1, 1'b0);
      #2;
      checks++; if (out_data !== 16'hA000) begin errors++; $display("FAIL stall_first: got %h, required A000", out_data); end
      drive(1'b1, 4'h6, 16'hA002, 1'b1, 1'b0);
      #2;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_reready: got %b, required 1", in_ready); end
      checks++; if (out_data !== 16'hA001) begin errors++; $display("FAIL stall_second: got %h, required A001", out_data); end
      drive(1'b0, 4'h6, 16'h0, 1'b1, 1'b0);
      #2;
      checks++; if (out_data !== 16'hA002) begin errors++; $display("FAIL stall_third: got %h, required A002", out_data); end
      drive(1'b0, 4'h6, 16'h0, 1'b1, 1'b0);
   endtask
`else
   task automatic test_comb_ready();
      drive(1'b1, 4'h5, 16'hC001, 1'b0, 1'b0);
      drive(1'b0, 4'h5, 16'h0, 1'b0, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL comb_ready_low: got %b, required 0", in_ready); end
      out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL comb_ready_follow: got %b, required 1", in_ready); end
      out_ready = 1'b0; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL comb_ready_drop: got %b, required 0", in_ready); end
      drive(1'b1, 4'h5, 16'hC002, 1'b1, 1'b0);
      #2;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL passthru_ready: got %b, required 1", in_ready); end
      drive(1'b0, 4'h5, 16'h0, 1'b1, 1'b0);
      #2;
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL passthru_occupancy: got %0d, required 1", occupancy); end
      checks++; if (out_data !== 16'hC002) begin errors++; $display("FAIL passthru_data: got %h, required C002", out_data); end
      drive(1'b0, 4'h5, 16'h0, 1'b1, 1'b0);
   endtask
`endif

   task automatic test_flush();
      drive(1'b1, 4'h3, 16'hB001, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
      drive(1'b1, 4'h3, 16'hB002, 1'b0, 1'b0);
`endif
      drive(1'b1, 4'hF, 16'hBEEF, 1'b0, 1'b1);
      #2;
      checks++; if (occupancy !== 2'(MAX_OCC)) begin errors++; $display("FAIL flush_full: got %0d, required %0d", occupancy, MAX_OCC); end
      drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
      checks++; if (out_ctrl !== 4'h0) begin errors++; $display("FAIL flush_ctrl: got %h, required 0", out_ctrl); end
      checks++; if (out_data !== 16'hB001) begin errors++; $display("FAIL flush_data_hold: got %h, required B001", out_data); end
      // An Accept in the flush cycle must be dropped.
      drive(1'b1, 4'hF, 16'hBEEF, 1'b1, 1'b1);
      #2;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_accept_ready: got %b, required 1", in_ready); end
      drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b, required 0", out_valid); end
      checks++; if (out_data !== 16'hB001) begin errors++; $display("FAIL flush_drop_data: got %h, required B001", out_data); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 4'h7, 16'hC0DE, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
      drive(1'b1, 4'h7, 16'hC0DF, 1'b0, 1'b0);
`endif
      drive(1'b0, 4'h7, 16'h0, 1'b0, 1'b0);
      #2;
      checks++; if (occupancy !== 2'(MAX_OCC)) begin errors++; $display("FAIL rstmid_full: got %0d, required %0d", occupancy, MAX_OCC); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rstmid_occupancy: got %0d, required 0", occupancy); end
      checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rstmid_data: got %h, required 0", out_data); end
      @(posedge CLK); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic fl, ordy;
      for (int i = 0; i < 300; i++) begin
         fl   = ($urandom_range(0, 19) == 0);
         ordy = fl ? 1'b0 : 1'($urandom_range(0, 1));
         drive(1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom), ordy, fl);
         #2;
         checks++; if (int'(occupancy) > MAX_OCC) begin errors++; $display("FAIL rand_occupancy: got %0d, required <= %0d", occupancy, MAX_OCC); end
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
      @(negedge CLK); #1;
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain_left: got %0d beats pending, required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_bubble();
`ifdef PIPE_STAGE_SKID_EN
      test_stall();
`else
      test_comb_ready();
`endif
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
